// File: rtl/strgen_timing.sv
// rtl/strgen_timing.sv - VGA raster timing generator, head of the 26-bit pixel stream
//
// Purpose:
//   Runs horizontal/vertical raster counters. On every enabled px_clk edge it
//   emits one stream word (active, VS, HS, YC, XC, R, G, B) for the current
//   raster position, then advances the counters. Downstream stages clone the
//   word and override the colour bits.
//
// Optional feature macro: STRGEN_PATTERN_EN
//   Defined   : active words carry 128-pixel colour bars, {B,G,R} = XC[9:7].
//   Undefined : R=G=B=0 always. No pattern logic is built.
//
// Ports:
//   px_clk         in   1   pixel clock, the only clock
//   reset_n        in   1   synchronous active-low reset
//   en             in   1   advance enable; low holds all state and outputs
//   strRGB_o       out  26  stream word: [0] active, [1] VS, [2] HS,
//                           [12:3] YC, [22:13] XC, [23] R, [24] G, [25] B
//   frame_start_o  out  1   one-cycle pulse with the word at position (0,0)
//
// H_ACTIVE+H_FP+H_SYNC+H_BP and V_ACTIVE+V_FP+V_SYNC+V_BP must each be <= 1024,
// because the raster counters are 10 bits wide.

module strgen_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0
) (
  input  logic        px_clk,
  input  logic        reset_n,
  input  logic        en,
  output logic [25:0] strRGB_o,
  output logic        frame_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Window bounds are compared in 11 bits so a bound equal to 1024 stays exact.
  localparam logic [10:0] C_H_ACT   = 11'(H_ACTIVE);
  localparam logic [10:0] C_V_ACT   = 11'(V_ACTIVE);
  localparam logic [10:0] C_HS_BEG  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] C_HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] C_VS_BEG  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] C_VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  C_H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0]  C_V_LAST  = 10'(V_TOTAL - 1);
  localparam logic        C_HS_ON   = 1'(HS_POL);
  localparam logic        C_VS_ON   = 1'(VS_POL);

  // Idle word: everything zero except the syncs, which sit at their inactive level.
  localparam logic [25:0] C_RESET_WORD = {23'd0, ~C_HS_ON, ~C_VS_ON, 1'b0};

  logic [9:0]  r_hc;
  logic [9:0]  r_vc;
  logic [25:0] r_word;
  logic        r_frame_start;

  logic [10:0] w_hc_x;
  logic [10:0] w_vc_x;
  logic        w_active;
  logic        w_hs;
  logic        w_vs;
  logic [2:0]  w_rgb;
  logic [25:0] w_word;
  logic        w_origin;
  logic        w_h_last;
  logic        w_v_last;

  always_comb begin
    w_hc_x   = {1'b0, r_hc};
    w_vc_x   = {1'b0, r_vc};
    w_active = (w_hc_x < C_H_ACT) && (w_vc_x < C_V_ACT);
    w_hs     = ((w_hc_x >= C_HS_BEG) && (w_hc_x < C_HS_END)) ? C_HS_ON : ~C_HS_ON;
    w_vs     = ((w_vc_x >= C_VS_BEG) && (w_vc_x < C_VS_END)) ? C_VS_ON : ~C_VS_ON;
`ifdef STRGEN_PATTERN_EN
    w_rgb    = w_active ? r_hc[9:7] : 3'b000;
`else
    w_rgb    = 3'b000;
`endif
    // {B,G,R} occupy bits [25:23], so w_rgb[2] lands on B.
    w_word   = {w_rgb, r_hc, r_vc, w_hs, w_vs, w_active};
    w_origin = (r_hc == 10'd0) && (r_vc == 10'd0);
    w_h_last = (r_hc == C_H_LAST);
    w_v_last = (r_vc == C_V_LAST);
  end

  always_ff @(posedge px_clk) begin
    if (!reset_n) begin
      r_hc          <= 10'd0;
      r_vc          <= 10'd0;
      r_word        <= C_RESET_WORD;
      r_frame_start <= 1'b0;
    end else if (en) begin
      r_word        <= w_word;
      r_frame_start <= w_origin;
      if (w_h_last) begin
        r_hc <= 10'd0;
        r_vc <= w_v_last ? 10'd0 : r_vc + 10'd1;
      end else begin
        r_hc <= r_hc + 10'd1;
      end
    end else begin
      // Stalled edges clear the pulse so it never stretches across a stall.
      r_frame_start <= 1'b0;
    end
  end

  assign strRGB_o      = r_word;
  assign frame_start_o = r_frame_start;

endmodule

// File: tb/tb_strgen_timing.sv
// tb/tb_strgen_timing.sv - directed self-checking bench for strgen_timing

module tb_strgen_timing;

  logic        clk;
  logic        a_rst_n, a_en, b_rst_n, b_en;
  logic [25:0] a_word, b_word;
  logic        a_fs, b_fs;

  int n_checks = 0;
  int n_errors = 0;

  // Instance A: standard 640x480 timing.
  strgen_timing u_dut_a (
    .px_clk        (clk),
    .reset_n       (a_rst_n),
    .en            (a_en),
    .strRGB_o      (a_word),
    .frame_start_o (a_fs)
  );

  // Instance B: tiny raster (32 x 15) so VS and frame wrap are reachable quickly.
  // VS window is lines 10..11, HS window pixels 20..27.
  strgen_timing #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(3),
    .HS_POL(0),    .VS_POL(0)
  ) u_dut_b (
    .px_clk        (clk),
    .reset_n       (b_rst_n),
    .en            (b_en),
    .strRGB_o      (b_word),
    .frame_start_o (b_fs)
  );

  wire       a_act = a_word[0];
  wire       a_vs  = a_word[1];
  wire       a_hs  = a_word[2];
  wire [9:0] a_yc  = a_word[12:3];
  wire [9:0] a_xc  = a_word[22:13];
  wire [2:0] a_rgb = a_word[25:23];
  wire       b_act = b_word[0];
  wire       b_vs  = b_word[1];
  wire [9:0] b_yc  = b_word[12:3];
  wire [9:0] b_xc  = b_word[22:13];

`ifdef STRGEN_PATTERN_EN
  localparam logic [2:0] EXP_RGB_300 = 3'b010;
`else
  localparam logic [2:0] EXP_RGB_300 = 3'b000;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n edges, then settle 1 time unit past the edge before sampling.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    a_rst_n = 1'b0; a_en = 1'b1;
    b_rst_n = 1'b0; b_en = 1'b1;

    // ---------------- Instance A ----------------
    step(3);
    chk("a_reset_word", a_word, 26'h0000006);
    chk("a_reset_fs",   a_fs,   0);

    a_rst_n = 1'b1;
    step(1);
    chk("a_first_word", a_word, 26'h0000007);
    chk("a_first_fs",   a_fs,   1);
    step(1);
    chk("a_second_xc",  a_xc,   1);
    chk("a_second_fs",  a_fs,   0);

    step(99);
    chk("a_pre_stall_xc", a_xc, 100);
    a_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("a_stall_xc", a_xc, 100);
      chk("a_stall_fs", a_fs, 0);
    end
    a_en = 1'b1;
    step(1);
    chk("a_post_stall_xc", a_xc, 101);

    step(538);
    chk("a_xc639",      a_xc,  639);
    chk("a_act639",     a_act, 1);
    step(1);
    chk("a_act640",     a_act, 0);
    chk("a_hs640",      a_hs,  1);
    step(15);
    chk("a_xc655",      a_xc,  655);
    chk("a_hs655",      a_hs,  1);
    step(1);
    chk("a_hs656",      a_hs,  0);
    step(95);
    chk("a_xc751",      a_xc,  751);
    chk("a_hs751",      a_hs,  0);
    step(1);
    chk("a_hs752",      a_hs,  1);
    chk("a_vs_line0",   a_vs,  1);

    step(47);
    chk("a_xc799",      a_xc,  799);
    chk("a_yc799",      a_yc,  0);
    step(1);
    chk("a_wrap_xc",    a_xc,  0);
    chk("a_wrap_yc",    a_yc,  1);
    chk("a_wrap_act",   a_act, 1);
    chk("a_wrap_fs",    a_fs,  0);

    step(300);
    chk("a_xc300",      a_xc,  300);
    chk("a_rgb300",     a_rgb, EXP_RGB_300);
    chk("a_act300",     a_act, 1);

    step(100);
    chk("a_xc400",      a_xc,  400);
    a_rst_n = 1'b0;
    step(1);
    chk("a_midrst_word", a_word, 26'h0000006);
    chk("a_midrst_fs",   a_fs,   0);
    a_rst_n = 1'b1;
    step(1);
    chk("a_restart_word", a_word, 26'h0000007);
    chk("a_restart_fs",   a_fs,   1);
    step(700);
    chk("a_xc700",      a_xc,  700);
    chk("a_rgb700",     a_rgb, 0);
    chk("a_act700",     a_act, 0);

    // ---------------- Instance B ----------------
    chk("b_reset_word", b_word, 26'h0000006);
    b_rst_n = 1'b1;
    step(1);
    chk("b_first_word", b_word, 26'h0000007);
    chk("b_first_fs",   b_fs,   1);
    b_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("b_stall0_fs", b_fs, 0);
      chk("b_stall0_xc", b_xc, 0);
    end
    b_en = 1'b1;
    step(1);
    chk("b_post_stall_xc", b_xc, 1);
    chk("b_post_stall_fs", b_fs, 0);

    step(318);
    chk("b_xc31_y9",   b_xc,  31);
    chk("b_yc9",       b_yc,  9);
    chk("b_vs9",       b_vs,  1);
    step(1);
    chk("b_yc10",      b_yc,  10);
    chk("b_vs10",      b_vs,  0);
    chk("b_act10",     b_act, 0);
    step(63);
    chk("b_yc11",      b_yc,  11);
    chk("b_vs11",      b_vs,  0);
    step(1);
    chk("b_yc12",      b_yc,  12);
    chk("b_vs12",      b_vs,  1);

    step(95);
    chk("b_last_xc",   b_xc,  31);
    chk("b_last_yc",   b_yc,  14);
    chk("b_last_fs",   b_fs,  0);
    step(1);
    chk("b_fwrap_word", b_word, 26'h0000007);
    chk("b_fwrap_fs",   b_fs,   1);
    step(1);
    chk("b_fwrap_fs_end", b_fs, 0);
    chk("b_fwrap_xc1",    b_xc, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
